// File: rtl/axi_port_arbiter_pkg.sv
// Shared types and constants for the AXI port arbiter: FSM encodings, grant IDs
// and the burst-length helper used to detect the final beat of a transaction.
package axi_port_arbiter_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_BUSY = 2'd1,
        R_GAP  = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_BUSY = 2'd1,
        W_GAP  = 2'd2
    } wr_state_t;

    localparam logic GNT_IC = 1'b0;
    localparam logic GNT_DC = 1'b1;

    // Beats in one transaction: (len+1) per burst times bursts per transaction (max 768).
    function automatic logic [9:0] total_beats(input logic [7:0] len, input logic [1:0] step);
        total_beats = ({2'b00, len} + 10'd1) * {8'd0, step};
    endfunction

endpackage

// File: rtl/axi_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Bit 0 is the I-cache read, bit 1 the D-cache read;
// on each taken grant the priority pointer moves to the requester that lost.
module axi_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr;  // 1: requester 1 wins a tie

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/axi_port_arbiter.sv
// Shares the single-ID AXI bridge between I-cache refill, D-cache refill and
// D-cache write-back; read and write FSMs run independently of each other.
module axi_port_arbiter
    import axi_port_arbiter_pkg::*;
#(
    parameter logic [7:0] IC_BURST_LEN = 8'd7,
    parameter logic [7:0] DC_BURST_LEN = 8'd7,
    parameter logic [1:0] BURST_STEP   = 2'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ic_rd_req,
    input  logic [31:0] ic_rd_addr,
    output logic        ic_rd_valid,
    output logic        ic_rd_done,
    input  logic        dc_rd_req,
    input  logic [31:0] dc_rd_addr,
    output logic        dc_rd_valid,
    output logic        dc_rd_done,
    output logic [31:0] rd_data,
    input  logic        dc_wr_req,
    input  logic [31:0] dc_wr_addr,
    input  logic [31:0] dc_wr_data,
    output logic        dc_wr_ack,
    output logic        dc_wr_done,
    output logic        axi_ar_en,
    output logic        axi_aw_en,
    output logic [31:0] cpu_rd_addr,
    output logic [31:0] cpu_wr_addr,
    output logic [31:0] cpu_wr_data,
    output logic [7:0]  ar_burst_len,
    output logic [7:0]  aw_burst_len,
    output logic [1:0]  ar_burst_step,
    output logic [1:0]  aw_burst_step,
    input  logic [31:0] cpu_rd_data,
    input  logic        bus_rd_data_ready,
    input  logic        bus_wr_data_ready,
    input  logic        bus_wr_data_finish,
    output logic [1:0]  rd_state_dbg,
    output logic [1:0]  wr_state_dbg
);

    // Handshake: requests are levels held until their done pulse and are only sampled
    // while the owning FSM is idle; valid/ack are single-cycle beat strobes qualified
    // by the bridge pulses and never raised without a grant.

    rd_state_t   rd_state, rd_state_n;
    wr_state_t   wr_state, wr_state_n;
    logic        rd_gnt;
    logic [31:0] rd_base, wr_base;
    logic [9:0]  rd_cnt, wr_cnt;
    logic [1:0]  rd_req, rd_gnt_vec;
    logic        dc_rd_elig;
    logic        rd_start, rd_beat, rd_last;
    logic        wr_start, wr_beat, wr_fin;

    assign rd_state_dbg = rd_state;
    assign wr_state_dbg = wr_state;

    // Write-back always precedes a D-cache refill so the refill never reads stale memory.
    assign dc_rd_elig = dc_rd_req && (wr_state == W_IDLE) && !dc_wr_req;
    assign rd_req     = {dc_rd_elig, ic_rd_req};
    assign rd_start   = (rd_state == R_IDLE) && (rd_req != 2'b00);
    assign rd_beat    = (rd_state == R_BUSY) && bus_rd_data_ready;
    assign rd_last    = rd_beat && ((rd_cnt + 10'd1) == total_beats(ar_burst_len, ar_burst_step));

    assign wr_start = (wr_state == W_IDLE) && dc_wr_req;
    assign wr_beat  = (wr_state == W_BUSY) && bus_wr_data_ready;
    assign wr_fin   = (wr_state == W_BUSY) && bus_wr_data_finish;

    axi_rr_arb2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (rd_req),
        .advance (rd_start),
        .gnt     (rd_gnt_vec)
    );

    always_comb begin
        rd_state_n = rd_state;
        case (rd_state)
            R_IDLE:  if (rd_start) rd_state_n = R_BUSY;
            R_BUSY:  if (rd_last) rd_state_n = R_GAP;
            R_GAP:   rd_state_n = R_IDLE;
            default: rd_state_n = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_n = wr_state;
        case (wr_state)
            W_IDLE:  if (wr_start) wr_state_n = W_BUSY;
            W_BUSY:  if (wr_fin) wr_state_n = W_GAP;
            W_GAP:   wr_state_n = W_IDLE;
            default: wr_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_state      <= R_IDLE;
            axi_ar_en     <= 1'b0;
            rd_gnt        <= GNT_IC;
            rd_base       <= 32'd0;
            rd_cnt        <= 10'd0;
            ar_burst_len  <= 8'd0;
            ar_burst_step <= 2'd0;
        end else begin
            rd_state  <= rd_state_n;
            axi_ar_en <= (rd_state_n == R_BUSY);
            if (rd_start) begin
                rd_gnt        <= rd_gnt_vec[1] ? GNT_DC : GNT_IC;
                rd_base       <= rd_gnt_vec[1] ? dc_rd_addr : ic_rd_addr;
                ar_burst_len  <= rd_gnt_vec[1] ? DC_BURST_LEN : IC_BURST_LEN;
                ar_burst_step <= BURST_STEP;
                rd_cnt        <= 10'd0;
            end else if (rd_beat) begin
                rd_cnt <= rd_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_state      <= W_IDLE;
            axi_aw_en     <= 1'b0;
            wr_base       <= 32'd0;
            wr_cnt        <= 10'd0;
            aw_burst_len  <= 8'd0;
            aw_burst_step <= 2'd0;
        end else begin
            wr_state  <= wr_state_n;
            axi_aw_en <= (wr_state_n == W_BUSY);
            if (wr_start) begin
                wr_base       <= dc_wr_addr;
                aw_burst_len  <= DC_BURST_LEN;
                aw_burst_step <= BURST_STEP;
                wr_cnt        <= 10'd0;
            end else if (wr_beat) begin
                wr_cnt <= wr_cnt + 10'd1;
            end
        end
    end

    // Because beat_cnt never wraps, each bridge re-issue lands on the next contiguous burst.
    assign cpu_rd_addr = rd_base + {20'd0, rd_cnt, 2'b00};
    assign cpu_wr_addr = wr_base + {20'd0, wr_cnt, 2'b00};
    assign rd_data     = cpu_rd_data;
    assign cpu_wr_data = dc_wr_data;

    assign ic_rd_valid = rd_beat && (rd_gnt == GNT_IC);
    assign dc_rd_valid = rd_beat && (rd_gnt == GNT_DC);
    assign ic_rd_done  = rd_last && (rd_gnt == GNT_IC);
    assign dc_rd_done  = rd_last && (rd_gnt == GNT_DC);
    assign dc_wr_ack   = wr_beat;
    assign dc_wr_done  = wr_fin;

endmodule

// File: tb/tb_axi_port_arbiter.sv
// Randomized bench for axi_port_arbiter: a step-1 instance and a step-2 instance share
// stimulus; expectations come from beat arithmetic and a round-robin priority bit.
module tb_axi_port_arbiter;

  localparam logic [7:0] LEN = 8'd7;

  logic        clk, reset;
  logic        ic_rd_req, dc_rd_req, dc_wr_req;
  logic [31:0] ic_rd_addr, dc_rd_addr, dc_wr_addr, dc_wr_data, cpu_rd_data;
  logic        bus_rd_data_ready, bus_wr_data_ready, bus_wr_data_finish;

  logic        ic_rd_valid, ic_rd_done, dc_rd_valid, dc_rd_done, dc_wr_ack, dc_wr_done;
  logic        axi_ar_en, axi_aw_en;
  logic [31:0] rd_data, cpu_rd_addr, cpu_wr_addr, cpu_wr_data;
  logic [7:0]  ar_burst_len, aw_burst_len;
  logic [1:0]  ar_burst_step, aw_burst_step, rd_state_dbg, wr_state_dbg;

  logic        s2_ic_rd_valid, s2_ic_rd_done, s2_dc_rd_valid, s2_dc_rd_done, s2_dc_wr_ack, s2_dc_wr_done;
  logic        s2_axi_ar_en, s2_axi_aw_en;
  logic [31:0] s2_rd_data, s2_cpu_rd_addr, s2_cpu_wr_addr, s2_cpu_wr_data;
  logic [7:0]  s2_ar_burst_len, s2_aw_burst_len;
  logic [1:0]  s2_ar_burst_step, s2_aw_burst_step, s2_rd_state_dbg, s2_wr_state_dbg;

  int passed = 0;
  int total  = 0;
  bit rr_ic_pri;   // model: I-cache wins the next read tie
  logic use2;      // read monitors look at the step-2 instance

  // read-side monitor, selectable between the two instances
  wire        m_ic_valid = use2 ? s2_ic_rd_valid : ic_rd_valid;
  wire        m_dc_valid = use2 ? s2_dc_rd_valid : dc_rd_valid;
  wire        m_ic_done  = use2 ? s2_ic_rd_done  : ic_rd_done;
  wire        m_dc_done  = use2 ? s2_dc_rd_done  : dc_rd_done;
  wire        m_ar_en    = use2 ? s2_axi_ar_en   : axi_ar_en;
  wire [31:0] m_rd_data  = use2 ? s2_rd_data     : rd_data;
  wire [31:0] m_rd_addr  = use2 ? s2_cpu_rd_addr : cpu_rd_addr;
  wire [7:0]  m_ar_len   = use2 ? s2_ar_burst_len  : ar_burst_len;
  wire [1:0]  m_ar_step  = use2 ? s2_ar_burst_step : ar_burst_step;

  axi_port_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_valid(ic_rd_valid), .ic_rd_done(ic_rd_done),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_valid(dc_rd_valid), .dc_rd_done(dc_rd_done),
    .rd_data(rd_data), .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .dc_wr_ack(dc_wr_ack), .dc_wr_done(dc_wr_done), .axi_ar_en(axi_ar_en), .axi_aw_en(axi_aw_en),
    .cpu_rd_addr(cpu_rd_addr), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .ar_burst_len(ar_burst_len), .aw_burst_len(aw_burst_len),
    .ar_burst_step(ar_burst_step), .aw_burst_step(aw_burst_step),
    .cpu_rd_data(cpu_rd_data), .bus_rd_data_ready(bus_rd_data_ready),
    .bus_wr_data_ready(bus_wr_data_ready), .bus_wr_data_finish(bus_wr_data_finish),
    .rd_state_dbg(rd_state_dbg), .wr_state_dbg(wr_state_dbg)
  );

  axi_port_arbiter #(.BURST_STEP(2'd2)) dut_s2 (
    .clk(clk), .reset(reset),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_valid(s2_ic_rd_valid), .ic_rd_done(s2_ic_rd_done),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_valid(s2_dc_rd_valid), .dc_rd_done(s2_dc_rd_done),
    .rd_data(s2_rd_data), .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .dc_wr_ack(s2_dc_wr_ack), .dc_wr_done(s2_dc_wr_done), .axi_ar_en(s2_axi_ar_en), .axi_aw_en(s2_axi_aw_en),
    .cpu_rd_addr(s2_cpu_rd_addr), .cpu_wr_addr(s2_cpu_wr_addr), .cpu_wr_data(s2_cpu_wr_data),
    .ar_burst_len(s2_ar_burst_len), .aw_burst_len(s2_aw_burst_len),
    .ar_burst_step(s2_ar_burst_step), .aw_burst_step(s2_aw_burst_step),
    .cpu_rd_data(cpu_rd_data), .bus_rd_data_ready(bus_rd_data_ready),
    .bus_wr_data_ready(bus_wr_data_ready), .bus_wr_data_finish(bus_wr_data_finish),
    .rd_state_dbg(s2_rd_state_dbg), .wr_state_dbg(s2_wr_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    ic_rd_req = 0; dc_rd_req = 0; dc_wr_req = 0;
    ic_rd_addr = 0; dc_rd_addr = 0; dc_wr_addr = 0; dc_wr_data = 0; cpu_rd_data = 0;
    bus_rd_data_ready = 0; bus_wr_data_ready = 0; bus_wr_data_finish = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0; clear_inputs(); use2 = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    rr_ic_pri = 1;
  endtask

  // model: who wins the read port given the live requests
  function automatic bit pick_ic(bit ic, bit dc_el);
    return ic && (!dc_el || rr_ic_pri);
  endfunction

  // drives a whole read transaction once the read port is granted
  task automatic run_read(input bit is_ic, input logic [31:0] base, input int nbeats);
    int n;
    logic [31:0] d;
    logic v, ov, dn;
    n = 0;
    while (!m_ar_en && n < 8) begin @(negedge clk); #1; n++; end
    total++; if (m_ar_en !== 1'b1) $display("FAIL rd_grant_wait: ar_en=%b want 1", m_ar_en); else passed++;
    total++; if (m_rd_addr !== base) $display("FAIL rd_start_addr: got %h want %h", m_rd_addr, base); else passed++;
    total++; if (m_ar_len !== LEN) $display("FAIL ar_burst_len: got %0d want %0d", m_ar_len, LEN); else passed++;
    for (int k = 0; k < nbeats; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); bus_rd_data_ready = 0; #1;
        total++; if ((m_ic_valid | m_dc_valid) !== 1'b0) $display("FAIL rd_valid_gap beat %0d: got 1 want 0", k); else passed++;
      end
      @(negedge clk);
      d = $urandom; cpu_rd_data = d; bus_rd_data_ready = 1; #1;
      v  = is_ic ? m_ic_valid : m_dc_valid;
      ov = is_ic ? m_dc_valid : m_ic_valid;
      dn = is_ic ? m_ic_done  : m_dc_done;
      total++; if (v !== 1'b1 || ov !== 1'b0) $display("FAIL rd_valid beat %0d: got %b/%b want 1/0", k, v, ov); else passed++;
      total++; if (m_rd_data !== d) $display("FAIL rd_data beat %0d: got %h want %h", k, m_rd_data, d); else passed++;
      total++; if (m_rd_addr !== base + 32'(4 * k)) $display("FAIL rd_addr beat %0d: got %h want %h", k, m_rd_addr, base + 32'(4 * k)); else passed++;
      total++; if (dn !== (k == nbeats - 1)) $display("FAIL rd_done beat %0d: got %b want %b", k, dn, (k == nbeats - 1)); else passed++;
    end
    @(negedge clk);
    bus_rd_data_ready = 0; cpu_rd_data = 0;
    if (is_ic) ic_rd_req = 0; else dc_rd_req = 0;
    #1;
    total++; if (m_ar_en !== 1'b0) $display("FAIL ar_en_gap: got %b want 0", m_ar_en); else passed++;
    total++; if ((m_ic_done | m_dc_done) !== 1'b0) $display("FAIL rd_done_after: got 1 want 0"); else passed++;
  endtask

  // drives a whole write transaction once the write port is granted
  task automatic run_write(input logic [31:0] base, input int nbeats);
    int n;
    logic [31:0] d;
    n = 0;
    while (!axi_aw_en && n < 8) begin @(negedge clk); #1; n++; end
    total++; if (axi_aw_en !== 1'b1) $display("FAIL wr_grant_wait: aw_en=%b want 1", axi_aw_en); else passed++;
    total++; if (cpu_wr_addr !== base) $display("FAIL wr_start_addr: got %h want %h", cpu_wr_addr, base); else passed++;
    total++; if (aw_burst_len !== LEN || aw_burst_step !== 2'd1) $display("FAIL aw_len_step: got %0d/%0d want %0d/1", aw_burst_len, aw_burst_step, LEN); else passed++;
    for (int k = 0; k < nbeats; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); bus_wr_data_ready = 0; #1;
        total++; if (dc_wr_ack !== 1'b0) $display("FAIL wr_ack_gap beat %0d: got 1 want 0", k); else passed++;
      end
      @(negedge clk);
      d = $urandom; dc_wr_data = d; bus_wr_data_ready = 1; #1;
      total++; if (dc_wr_ack !== 1'b1) $display("FAIL wr_ack beat %0d: got %b want 1", k, dc_wr_ack); else passed++;
      total++; if (cpu_wr_data !== d) $display("FAIL wr_data beat %0d: got %h want %h", k, cpu_wr_data, d); else passed++;
      total++; if (cpu_wr_addr !== base + 32'(4 * k)) $display("FAIL wr_addr beat %0d: got %h want %h", k, cpu_wr_addr, base + 32'(4 * k)); else passed++;
      total++; if (dc_wr_done !== 1'b0) $display("FAIL wr_done_early beat %0d: got 1 want 0", k); else passed++;
    end
    @(negedge clk);
    bus_wr_data_ready = 0; bus_wr_data_finish = 1; #1;
    total++; if (dc_wr_done !== 1'b1 || dc_wr_ack !== 1'b0) $display("FAIL wr_done: got done=%b ack=%b want 1/0", dc_wr_done, dc_wr_ack); else passed++;
    @(negedge clk);
    bus_wr_data_finish = 0; dc_wr_req = 0; dc_wr_data = 0; #1;
    total++; if (axi_aw_en !== 1'b0 || dc_wr_done !== 1'b0) $display("FAIL aw_en_gap: got en=%b done=%b want 0/0", axi_aw_en, dc_wr_done); else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 0; clear_inputs(); use2 = 0;
    @(negedge clk); #1;
    total++; if ({axi_ar_en, axi_aw_en, ic_rd_valid, ic_rd_done, dc_rd_valid, dc_rd_done, dc_wr_ack, dc_wr_done} !== 8'd0)
      $display("FAIL reset_ctrl: got %b want 0", {axi_ar_en, axi_aw_en, ic_rd_valid, ic_rd_done, dc_rd_valid, dc_rd_done, dc_wr_ack, dc_wr_done}); else passed++;
    total++; if ({cpu_rd_addr, cpu_wr_addr} !== 64'd0) $display("FAIL reset_addr: got %h/%h want 0", cpu_rd_addr, cpu_wr_addr); else passed++;
    total++; if ({ar_burst_len, aw_burst_len, ar_burst_step, aw_burst_step} !== 20'd0) $display("FAIL reset_len: got %h want 0", {ar_burst_len, aw_burst_len, ar_burst_step, aw_burst_step}); else passed++;
    @(negedge clk); reset = 1; rr_ic_pri = 1;
    // stray bridge pulses with no request must be ignored
    @(negedge clk);
    bus_rd_data_ready = 1; bus_wr_data_ready = 1; bus_wr_data_finish = 1; #1;
    total++; if ({ic_rd_valid, dc_rd_valid, ic_rd_done, dc_rd_done, dc_wr_ack, dc_wr_done} !== 6'd0) $display("FAIL stray_idle: got %b want 0", {ic_rd_valid, dc_rd_valid, ic_rd_done, dc_rd_done, dc_wr_ack, dc_wr_done}); else passed++;
    @(negedge clk); #1;
    total++; if ({axi_ar_en, axi_aw_en} !== 2'b00) $display("FAIL stray_en: got %b want 00", {axi_ar_en, axi_aw_en}); else passed++;
    clear_inputs();
  endtask

  task automatic test_ic_read();
    do_reset();
    @(negedge clk);
    ic_rd_req = 1; ic_rd_addr = 32'h1000; #1;
    total++; if (axi_ar_en !== 1'b0) $display("FAIL ar_en_same_cycle: got %b want 0", axi_ar_en); else passed++;
    @(negedge clk); #1;
    total++; if (axi_ar_en !== 1'b1) $display("FAIL ar_en_next_cycle: got %b want 1", axi_ar_en); else passed++;
    total++; if (ar_burst_step !== 2'd1) $display("FAIL ar_step: got %0d want 1", ar_burst_step); else passed++;
    run_read(1'b1, 32'h1000, (int'(LEN) + 1) * 1);
  endtask

  task automatic test_round_robin();
    bit want_ic;
    logic [31:0] ia, da;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      ia = $urandom & 32'h00FF_FFFC; da = $urandom & 32'h00FF_FFFC;
      @(negedge clk);
      ic_rd_req = 1; ic_rd_addr = ia; dc_rd_req = 1; dc_rd_addr = da;
      for (int t = 0; t < 2; t++) begin
        want_ic = pick_ic(ic_rd_req, dc_rd_req);
        rr_ic_pri = !want_ic;
        run_read(want_ic, want_ic ? ia : da, int'(LEN) + 1);
      end
    end
  endtask

  task automatic test_burst_step();
    do_reset();
    use2 = 1;
    @(negedge clk);
    dc_rd_req = 1; dc_rd_addr = 32'h2000;
    @(negedge clk); #1;
    total++; if (m_ar_step !== 2'd2) $display("FAIL step2_step: got %0d want 2", m_ar_step); else passed++;
    run_read(1'b0, 32'h2000, (int'(LEN) + 1) * 2);
    use2 = 0;
  endtask

  task automatic test_wr_priority();
    do_reset();
    @(negedge clk);
    dc_wr_req = 1; dc_wr_addr = 32'h3000; dc_rd_req = 1; dc_rd_addr = 32'h4000;
    @(negedge clk); #1;
    total++; if (axi_aw_en !== 1'b1) $display("FAIL wr_first_aw: got %b want 1", axi_aw_en); else passed++;
    repeat (3) begin
      @(negedge clk); #1;
      total++; if (axi_ar_en !== 1'b0) $display("FAIL dc_rd_held: ar_en got %b want 0", axi_ar_en); else passed++;
    end
    @(negedge clk);
    ic_rd_req = 1; ic_rd_addr = 32'h1000;
    @(negedge clk); #1;
    total++; if (axi_ar_en !== 1'b1) $display("FAIL ic_during_wr: ar_en got %b want 1", axi_ar_en); else passed++;
    run_read(1'b1, 32'h1000, int'(LEN) + 1);
    repeat (3) begin
      @(negedge clk); #1;
      total++; if (axi_ar_en !== 1'b0) $display("FAIL dc_rd_held2: ar_en got %b want 0", axi_ar_en); else passed++;
    end
    run_write(32'h3000, int'(LEN) + 1);
    total++; if (axi_ar_en !== 1'b0) $display("FAIL dc_rd_wr_gap: ar_en got %b want 0", axi_ar_en); else passed++;
    run_read(1'b0, 32'h4000, int'(LEN) + 1);
  endtask

  task automatic test_write();
    logic [31:0] a;
    do_reset();
    @(negedge clk);
    dc_wr_req = 1; dc_wr_addr = 32'h3000;
    @(negedge clk); #1;
    total++; if (axi_aw_en !== 1'b1) $display("FAIL aw_en_next_cycle: got %b want 1", axi_aw_en); else passed++;
    run_write(32'h3000, int'(LEN) + 1);
    a = $urandom & 32'h0FFF_FFFC;
    @(negedge clk);
    dc_wr_req = 1; dc_wr_addr = a;
    run_write(a, int'(LEN) + 1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    ic_rd_req = 1; ic_rd_addr = 32'h1000;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); bus_rd_data_ready = 1; cpu_rd_data = $urandom; #1;
      total++; if (ic_rd_valid !== 1'b1) $display("FAIL pre_reset_valid beat %0d: got %b want 1", k, ic_rd_valid); else passed++;
    end
    @(negedge clk);
    reset = 0; ic_rd_req = 0; cpu_rd_data = 0;
    @(negedge clk); #1;
    total++; if ({axi_ar_en, ic_rd_valid, ic_rd_done, dc_rd_valid, dc_rd_done} !== 5'd0) $display("FAIL mid_reset_ctrl: got %b want 0", {axi_ar_en, ic_rd_valid, ic_rd_done, dc_rd_valid, dc_rd_done}); else passed++;
    total++; if (cpu_rd_addr !== 32'd0 || ar_burst_len !== 8'd0) $display("FAIL mid_reset_regs: got %h/%0d want 0/0", cpu_rd_addr, ar_burst_len); else passed++;
    @(negedge clk);
    reset = 1; bus_rd_data_ready = 0; rr_ic_pri = 1;
    @(negedge clk); #1;
    total++; if (ic_rd_done !== 1'b0) $display("FAIL no_done_after_reset: got 1 want 0"); else passed++;
    ic_rd_req = 1; ic_rd_addr = 32'h5000;
    run_read(1'b1, 32'h5000, int'(LEN) + 1);
  endtask

  initial begin
    reset = 0; clear_inputs(); use2 = 0; rr_ic_pri = 1;
    test_reset();
    test_ic_read();
    test_round_robin();
    test_burst_step();
    test_wr_priority();
    test_write();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
